// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: datapath width, register index width, load funct3 codes
// and the load-queue entry layout.
package rv32_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [2:0] {
    F3Lb  = 3'b000,
    F3Lh  = 3'b001,
    F3Lw  = 3'b010,
    F3Lbu = 3'b100,
    F3Lhu = 3'b101
  } funct3_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [2:0]       funct3;
    logic [1:0]       addr_lo;
  } lq_entry_t;

  function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] addr_lo);
    return ((funct3 == F3Lh || funct3 == F3Lhu) && addr_lo[0]) ||
           (funct3 == F3Lw && addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Execute / memory-response / register-file write bundle for wb_ctrl.
// Trap outputs exist only when WB_MISALIGN_TRAP_EN is defined.
interface wb_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic            ex_is_load;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_result;
  logic [2:0]      ex_funct3;
  logic [1:0]      ex_addr_lo;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            lq_empty;
`ifdef WB_MISALIGN_TRAP_EN
  logic            trap_misalign;
  logic [4:0]      trap_rd;
`endif

  modport slave (
    input  ex_valid, ex_is_load, ex_rd, ex_result, ex_funct3, ex_addr_lo,
    input  mem_rvalid, mem_rdata, rs1_idx, rs2_idx,
`ifdef WB_MISALIGN_TRAP_EN
    output trap_misalign, trap_rd,
`endif
    output ex_ready, wb_we, wb_rd, wb_data, rs1_busy, rs2_busy, lq_empty
  );

  modport master (
    output ex_valid, ex_is_load, ex_rd, ex_result, ex_funct3, ex_addr_lo,
    output mem_rvalid, mem_rdata, rs1_idx, rs2_idx,
`ifdef WB_MISALIGN_TRAP_EN
    input  trap_misalign, trap_rd,
`endif
    input  ex_ready, wb_we, wb_rd, wb_data, rs1_busy, rs2_busy, lq_empty
  );
endinterface

// File: rtl/wb_ctrl_load_ext.sv
// RV32I load extension: selects and sign/zero-extends a byte, halfword or word
// from an aligned 32-bit memory word.
module load_ext
  import rv32_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);
  logic [31:0] w_shifted;
  logic [15:0] w_half;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
  // Halfword lane uses only addr_lo[1]; a misaligned offset still picks a lane.
  assign w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3Lb:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3Lbu:   o_data = {24'h0, w_shifted[7:0]};
      F3Lh:    o_data = {{16{w_half[15]}}, w_half};
      F3Lhu:   o_data = {16'h0, w_half};
      F3Lw:    o_data = i_rdata;
      default: o_data = '0;
    endcase
  end
endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates ALU results and in-order load responses onto the
// register-file write port and tracks pending load destinations. Option: WB_MISALIGN_TRAP_EN.
module wb_ctrl #(
  parameter int unsigned LQ_DEPTH = 4,
  parameter int unsigned XLEN     = 32
) (
  input logic       clk,
  input logic       resetn,
  wb_ctrl_if.slave  bus
);
  import rv32_pkg::*;

  localparam int unsigned AW = $clog2(LQ_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wptr, r_rptr;
  lq_entry_t     r_lq [LQ_DEPTH];
  logic [PW-1:0] r_pend [32];
  logic          r_wb_we;
  logic [4:0]    r_wb_rd;
  logic [XLEN-1:0] r_wb_data;

  logic          w_full, w_empty, w_accept, w_push, w_pop, w_alu, w_skip;
  lq_entry_t     w_head;
  logic [31:0]   w_load_data;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head   = r_lq[r_rptr[AW-1:0]];

  assign bus.ex_ready = !bus.mem_rvalid && !(bus.ex_is_load && w_full);
  assign w_accept     = bus.ex_valid && bus.ex_ready;
  assign w_alu        = w_accept && !bus.ex_is_load;
  assign w_pop        = bus.mem_rvalid && !w_empty;

`ifdef WB_MISALIGN_TRAP_EN
  assign w_skip = is_misaligned(bus.ex_funct3, bus.ex_addr_lo);
`else
  assign w_skip = 1'b0;
`endif
  assign w_push = w_accept && bus.ex_is_load && !w_skip;

  load_ext u_load_ext (
    .i_funct3  (w_head.funct3),
    .i_addr_lo (w_head.addr_lo),
    .i_rdata   (bus.mem_rdata),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_lq[r_wptr[AW-1:0]] <= '{rd: bus.ex_rd, funct3: bus.ex_funct3,
                                          addr_lo: bus.ex_addr_lo};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      // Load response owns the slot; ex_ready is low whenever it is present.
      if (w_pop) begin
        r_wb_we <= (w_head.rd != 5'd0);
        if (w_head.rd != 5'd0) begin
          r_wb_rd   <= w_head.rd;
          r_wb_data <= XLEN'(w_load_data);
        end
      end else if (w_alu) begin
        r_wb_we <= (bus.ex_rd != 5'd0);
        if (bus.ex_rd != 5'd0) begin
          r_wb_rd   <= bus.ex_rd;
          r_wb_data <= bus.ex_result;
        end
      end else begin
        r_wb_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (w_push && bus.ex_rd == REG_W'(i))     r_pend[i] <= r_pend[i] + PW'(1);
        else if (w_pop && w_head.rd == REG_W'(i)) r_pend[i] <= r_pend[i] - PW'(1);
      end
    end
  end

`ifdef WB_MISALIGN_TRAP_EN
  logic       r_trap;
  logic [4:0] r_trap_rd;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_trap    <= 1'b0;
      r_trap_rd <= '0;
    end else begin
      r_trap <= w_accept && bus.ex_is_load && w_skip;
      if (w_accept && bus.ex_is_load && w_skip) r_trap_rd <= bus.ex_rd;
    end
  end
  assign bus.trap_misalign = r_trap;
  assign bus.trap_rd       = r_trap_rd;
`endif

  assign bus.wb_we    = r_wb_we;
  assign bus.wb_rd    = r_wb_rd;
  assign bus.wb_data  = r_wb_data;
  assign bus.lq_empty = w_empty;
  assign bus.rs1_busy = (r_pend[bus.rs1_idx] != '0) && (bus.rs1_idx != 5'd0);
  assign bus.rs2_busy = (r_pend[bus.rs2_idx] != '0) && (bus.rs2_idx != 5'd0);
endmodule

// File: tb/tb_wb_ctrl.sv
// Scoreboard bench for wb_ctrl: a load-queue model predicts every register-file write.
module tb_wb_ctrl;
  localparam int unsigned LQ_DEPTH = 4;

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] alo;
  } ld_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  ld_t  mq[$];
  wr_t  sq[$];
  logic [31:0] rf [32];

  wb_ctrl_if #(.XLEN(32)) bus ();

  wb_ctrl #(.LQ_DEPTH(LQ_DEPTH), .XLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] alo,
                                      input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*alo +: 8];
    h = alo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  // One cycle of stimulus, applied at the falling edge; the model predicts the write.
  task automatic drive(input logic v, input logic ld, input logic [4:0] rd,
                       input logic [31:0] res, input logic [2:0] f3, input logic [1:0] alo,
                       input logic rv, input logic [31:0] rdata);
    logic rdy;
    ld_t  e;
    @(negedge clk);
    bus.ex_valid = v;   bus.ex_is_load = ld; bus.ex_rd = rd;     bus.ex_result = res;
    bus.ex_funct3 = f3; bus.ex_addr_lo = alo; bus.mem_rvalid = rv; bus.mem_rdata = rdata;
    rdy = !rv && !(ld && mq.size() == LQ_DEPTH);
    if (rv) begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.rd != 0) sq.push_back('{rd: e.rd, data: ext(e.f3, e.alo, rdata)});
      end
    end else if (v && rdy) begin
      if (ld) mq.push_back('{rd: rd, f3: f3, alo: alo});
      else if (rd != 0) sq.push_back('{rd: rd, data: res});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.wb_we === 1'b1) begin
      wr_t e;
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write rd=%0d data=%h required no write", bus.wb_rd,
                 bus.wb_data);
      end else begin
        e = sq.pop_front();
        if (bus.wb_rd !== e.rd || bus.wb_data !== e.data) begin
          errors++;
          $display("FAIL write rd=%0d data=%h required rd=%0d data=%h", bus.wb_rd,
                   bus.wb_data, e.rd, e.data);
        end
      end
      rf[bus.wb_rd] = bus.wb_data;
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    bus.rs1_idx = 5'd5; bus.rs2_idx = 5'd0;
    bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_rd = 0; bus.ex_result = 0;
    bus.ex_funct3 = 0; bus.ex_addr_lo = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.wb_we !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_wb we=%b rd=%0d data=%h required 0/0/0", bus.wb_we, bus.wb_rd,
               bus.wb_data);
    end
    checks++;
    if (bus.lq_empty !== 1'b1 || bus.rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_lq empty=%b busy=%b required 1/0", bus.lq_empty, bus.rs1_busy);
    end
    resetn = 1'b1;
  endtask

  task automatic test_alu();
    drive(1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    drive(1, 0, 0, 32'h12345678, 0, 0, 0, 0);
    #1;
    checks++;
    if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_latency we=%b rd=%0d data=%h required 1/5/deadbeef", bus.wb_we,
               bus.wb_rd, bus.wb_data);
    end
    idle(1);
    #1;
    checks++;
    if (bus.wb_we !== 1'b0) begin
      errors++;
      $display("FAIL alu_rd0 we=%b required 0", bus.wb_we);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0] f3s [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
    logic [1:0] alos [5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    bus.rs1_idx = 5'd3;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 3, 0, f3s[i], alos[i], 0, 0);
      idle(1);
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b1 || bus.lq_empty !== 1'b0) begin
        errors++;
        $display("FAIL load_pending busy=%b empty=%b required 1/0", bus.rs1_busy,
                 bus.lq_empty);
      end
      drive(0, 0, 0, 0, 0, 0, 1, 32'h1280_8000);
      idle(1);
    end
    idle(1);
  endtask

  task automatic test_full();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) drive(1, 1, 5'(10 + i), 0, 3'b010, 0, 0, 0);
      drive(1, 1, 14, 0, 3'b010, 0, 0, 0);
      #1;
      checks++;
      if (bus.ex_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_load ready=%b required 0", bus.ex_ready);
      end
      drive(1, 0, 20, 32'hA5A5_0000 + r, 0, 0, 0, 0);
      #1;
      checks++;
      if (bus.ex_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_alu ready=%b required 1", bus.ex_ready);
      end
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1, 32'h1000 * (r + 1) + i);
      idle(1);
    end
  endtask

  task automatic test_collision();
    drive(1, 1, 9, 0, 3'b010, 0, 0, 0);
    drive(1, 0, 21, 32'hCAFE_F00D, 0, 0, 1, 32'h5555_AAAA);
    #1;
    checks++;
    if (bus.ex_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_ready ready=%b required 0", bus.ex_ready);
    end
    drive(1, 0, 21, 32'hCAFE_F00D, 0, 0, 0, 0);
    idle(2);
  endtask

  task automatic test_waw();
    bus.rs1_idx = 5'd7; bus.rs2_idx = 5'd7;
    drive(1, 1, 7, 0, 3'b010, 0, 0, 0);
    drive(1, 1, 7, 0, 3'b010, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
    idle(1);
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL waw_busy1 busy=%b/%b required 1/1", bus.rs1_busy, bus.rs2_busy);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
    idle(2);
    checks++;
    if (bus.rs1_busy !== 1'b0 || rf[7] !== 32'h2222_2222) begin
      errors++;
      $display("FAIL waw_final busy=%b rf7=%h required 0/22222222", bus.rs1_busy, rf[7]);
    end
  endtask

  task automatic test_reset_mid();
    bus.rs1_idx = 5'd8; bus.rs2_idx = 5'd9;
    drive(1, 1, 8, 0, 3'b010, 0, 0, 0);
    drive(1, 1, 9, 0, 3'b010, 0, 0, 0);
    idle(1);
    #2 resetn = 1'b0;
    mq.delete();
    #1;
    checks++;
    if (bus.lq_empty !== 1'b1 || bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 ||
        bus.wb_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset empty=%b busy=%b/%b we=%b required 1/0/0/0", bus.lq_empty,
               bus.rs1_busy, bus.rs2_busy, bus.wb_we);
    end
    @(negedge clk) resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
    idle(1);
    #1;
    checks++;
    if (bus.wb_we !== 1'b0) begin
      errors++;
      $display("FAIL stale_rvalid we=%b required 0", bus.wb_we);
    end
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_alu();
    test_load_ext();
    test_full();
    test_collision();
    test_waw();
    test_reset_mid();
    idle(2);
    checks++;
    if (sq.size() != 0 || bus.lq_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain pending=%0d empty=%b required 0/1", sq.size(), bus.lq_empty);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Writeback controller: the write-side initiator that drives the register file's write port (write enable, destination index, write data).
- Merges single-cycle ALU results with loads whose memory response arrives later.
- Performs RV32I load extension (LB/LH/LW/LBU/LHU).
- Keeps a scoreboard of destinations with loads still outstanding, so issue logic can stall on a RAW hazard.

Parameters:
- LQ_DEPTH, 4, maximum number of outstanding loads (power of 2, ≥2).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute stage presents a result or a load issue.
- ex_ready  out  1  controller accepts this cycle.
- ex_is_load  in  1  1 = load issue (data comes later), 0 = ALU result.
- ex_rd  in  5  destination register index.
- ex_result  in  XLEN  ALU result; ignored for loads.
- ex_funct3  in  3  load width/sign code (RV32I encoding).
- ex_addr_lo  in  2  load byte offset, address[1:0].
- mem_rvalid  in  1  load data valid; in-order, cannot be back-pressured.
- mem_rdata  in  32  raw aligned word.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  register-file write index.
- wb_data  out  XLEN  register-file write data.
- rs1_idx, rs2_idx  in  5 each  source indices being decoded.
- rs1_busy, rs2_busy  out  1 each  source has a pending load.
- lq_empty  out  1  no outstanding loads.

Behaviour:
- Reset values:
  - wb_we=0, wb_rd=0, wb_data=0.
  - Load queue empty: lq_empty=1.
  - Scoreboard cleared.
- Asynchronous reset mid-operation discards all outstanding loads. mem_rvalid pulses after reset are ignored until a new load is queued.
- Writeback pipeline:
  - wb_we/wb_rd/wb_data are registered: one cycle latency from the accepting edge.
  - A result accepted or a response received at edge N is driven during cycle N+1 and written by the register file on the following negedge.
- Write suppression: wb_we is never asserted with wb_rd=0. An rd=0 ALU result or load retires silently.
- Arbitration:
  - A mem_rvalid response has priority for the single writeback slot.
  - ex_ready = !mem_rvalid && !(ex_is_load && lq_full).
  - ex_ready is combinational; ex_valid must not depend on ex_ready.
- ALU accept: on ex_valid && ex_ready && !ex_is_load, register {rd, result} into the writeback slot.
- Load issue:
  - On ex_valid && ex_ready && ex_is_load, push {rd, funct3, addr_lo} into a circular FIFO of LQ_DEPTH entries.
  - Read/write pointers are log2(LQ_DEPTH)+1 bits; full/empty are decided by the MSB.
  - Pointers wrap modulo 2·LQ_DEPTH.
- Load response: on mem_rvalid with the queue non-empty:
  - Pop the head entry.
  - Shift = addr_lo·8.
  - funct3 000 (LB) sign-extends byte; 100 (LBU) zero-extends byte.
  - 001 (LH) sign-extends halfword at addr_lo[1]·16; 101 (LHU) zero-extends it.
  - 010 (LW) takes the word.
  - Other funct3 values write 0.
  - mem_rvalid with an empty queue is ignored and wb_we stays 0.
- Simultaneous events:
  - A push and a pop in the same cycle are legal when the queue is full only if the pop occurs. Because ex_ready=0 whenever mem_rvalid=1, push and pop never coincide.
- Scoreboard:
  - One pending-load counter per register (width log2(LQ_DEPTH)+1).
  - Incremented on push, decremented on pop of the same rd.
  - rsN_busy = (counter[rsN_idx] != 0) && rsN_idx != 0.
  - Combinational from current state; a pop in the current cycle does not clear busy until after the edge.
- Write-after-write: two queued loads to the same rd keep it busy until both retire; the later write wins.

Optional Feature:
- Macro: WB_MISALIGN_TRAP_EN.
- Defined:
  - A load issue with funct3 001/101 and addr_lo[0]=1, or 010 and addr_lo!=0, is accepted (ex_ready as normal) but not queued.
  - Output trap_misalign (1 bit) pulses high for one cycle, registered, together with trap_rd (5 bits).
- Undefined:
  - Those ports are absent.
  - Misaligned loads are queued and extracted using only the bits computed from addr_lo; the upper bytes are whatever the shift produces.

Decomposition:
- Shared package (rv32_pkg): funct3 load codes (LB, LH, LW, LBU, LHU), XLEN, register index width.
- One sub-module, load_ext: combinational {funct3, addr_lo, rdata} → extended word. It is reused by a future store-aligner check.
- Load queue stays inline.

Test Plan:
- Reset with resetn=0 mid-queue (2 loads outstanding) → lq_empty=1, all busy=0, wb_we=0; a following mem_rvalid produces no write.
- ALU result rd=5, result 0xDEADBEEF accepted at edge N → wb_we=1, wb_rd=5, wb_data=0xDEADBEEF in cycle N+1. rd=0 → wb_we stays 0.
- LB rd=3, addr_lo=2, mem_rdata=0x1280_0000 → wb_data=0xFFFFFF80. LBU → 0x00000080. LHU addr_lo=2 → 0x00001280.
- Issue 4 loads (LQ_DEPTH=4) → ex_ready=0 for a fifth load, while ex_ready=1 for an ALU result. Responses retire in order; the pointers wrap and the queue refills cleanly.
- mem_rvalid and ex_valid ALU in the same cycle → ex_ready=0; the load writes first and the ALU result is written one cycle later.
- Two loads to rd=7 → rs1_busy(7)=1 after the first pop and 0 after the second; the final register value is the second response.
